tx_pattern_sequencer: RTL and testbench

Sequences the serial bit stream fed to the behavioral transmitter's `data_i` input, one bit per `clk_i`. After a start request it emits a fixed preamble, then a PRBS7 training burst of programmable length, then user payload words serialized LSB-first under a valid/ready handshake. It sits between the link-test stimulus (or firmware model) and the TX analog model. It is the only block allowed to drive TX data during a link bring-up sequence.

---
 rtl/tx_pattern_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_tx_pattern_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_sequencer.sv
// Serial TX pattern sequencer: preamble, PRBS7 training burst, then LSB-first
// payload words under a valid/ready handshake. One bit per clock on data_o.
module tx_pattern_sequencer #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned PRE_LEN = 32,
  parameter int unsigned LEN_W   = 16
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [LEN_W-1:0]  prbs_len_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              data_o,
  output logic [1:0]        state_o,
  output logic              busy_o,
  output logic              underflow_o,
  output logic              done_o
);

  localparam int unsigned PcW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int unsigned BcW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StPrbs = 2'd2,
    StData = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PcW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]  prbs_cnt_q, prbs_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BcW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              loaded_q, loaded_d;
  logic              stop_pend_q, stop_pend_d;
  logic              data_q, data_d;
  logic              underflow_q, underflow_d;
  logic              done_q, done_d;

  logic pre_last, prbs_last, word_last, xfer, stop_eff;

  assign pre_last  = (pre_cnt_q == PcW'(PRE_LEN - 1));
  assign prbs_last = (prbs_cnt_q == len_q - LEN_W'(1));
  assign word_last = (bit_cnt_q == BcW'(WORD_W - 1));
  assign stop_eff  = stop_i | stop_pend_q;

  // Ready depends only on state and counters; it opens one cycle early in
  // PRE/PRBS so the first payload bit follows the last training bit directly.
  always_comb begin
    word_ready_o = 1'b0;
    unique case (state_q)
      StPre:   word_ready_o = pre_last && (len_q == '0);
      StPrbs:  word_ready_o = prbs_last;
      StData:  word_ready_o = !stop_pend_q && (!loaded_q || word_last);
      default: word_ready_o = 1'b0;
    endcase
  end

  assign xfer = word_ready_o & word_valid_i;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    prbs_cnt_d  = prbs_cnt_q;
    len_d       = len_q;
    lfsr_d      = lfsr_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    loaded_d    = loaded_q;
    stop_pend_d = stop_pend_q;
    underflow_d = underflow_q;
    data_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        loaded_d    = 1'b0;
        stop_pend_d = 1'b0;
        bit_cnt_d   = '0;
        if (start_i && !stop_i) begin
          state_d     = StPre;
          len_d       = prbs_len_i;
          underflow_d = 1'b0;
          pre_cnt_d   = '0;
        end
      end
      StPre: begin
        data_d = ~pre_cnt_q[0];
        if (stop_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (pre_last) begin
          pre_cnt_d = '0;
          if (len_q != '0) begin
            state_d    = StPrbs;
            lfsr_d     = 7'h7F;
            prbs_cnt_d = '0;
          end else begin
            state_d = StData;
          end
        end else begin
          pre_cnt_d = pre_cnt_q + PcW'(1);
        end
      end
      StPrbs: begin
        data_d = lfsr_q[6];
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        if (stop_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (prbs_last) begin
          prbs_cnt_d = '0;
          state_d    = StData;
        end else begin
          prbs_cnt_d = prbs_cnt_q + LEN_W'(1);
        end
      end
      StData: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (loaded_q) begin
          data_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
          if (word_last) begin
            loaded_d  = 1'b0;
            bit_cnt_d = '0;
            if (stop_eff && !xfer) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BcW'(1);
          end
        end else if (stop_eff && !xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (!stop_eff) begin
          // Empty slot: emit 0 and flag it, keep waiting for a word.
          underflow_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A handshake only loads when the sequence actually continues into DATA.
    if (xfer && (state_d == StData)) begin
      shreg_d   = word_i;
      loaded_d  = 1'b1;
      bit_cnt_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q     <= StIdle;
      pre_cnt_q   <= '0;
      prbs_cnt_q  <= '0;
      len_q       <= '0;
      lfsr_q      <= 7'h7F;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      loaded_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      data_q      <= 1'b0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      prbs_cnt_q  <= prbs_cnt_d;
      len_q       <= len_d;
      lfsr_q      <= lfsr_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      loaded_q    <= loaded_d;
      stop_pend_q <= stop_pend_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
    end
  end

  assign data_o      = data_q;
  assign state_o     = state_q;
  assign busy_o      = (state_q != StIdle);
  assign underflow_o = underflow_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_tx_pattern_sequencer.sv
// Directed self-checking bench for tx_pattern_sequencer (WORD_W=16, PRE_LEN=32).
module tb_tx_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start, stop, word_valid;
  logic [15:0] prbs_len, word;
  logic        word_ready, data, busy, underflow, done;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  tx_pattern_sequencer #(
    .WORD_W (16),
    .PRE_LEN(32),
    .LEN_W  (16)
  ) dut (
    .clk_i       (clk),
    .rstb_i      (rstb),
    .start_i     (start),
    .stop_i      (stop),
    .prbs_len_i  (prbs_len),
    .word_i      (word),
    .word_valid_i(word_valid),
    .word_ready_o(word_ready),
    .data_o      (data),
    .state_o     (state),
    .busy_o      (busy),
    .underflow_o (underflow),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0; start = 1'b0; stop = 1'b0; word_valid = 1'b0;
    prbs_len = '0; word = '0;
    tick();
    tick();
    rstb = 1'b1;
    tick();
  endtask

  // Accept a start with the given length; returns in PRE cycle 0.
  task automatic kick(input logic [15:0] len);
    prbs_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    kick(16'd20);
    repeat (35) tick();
    checks++;
    if (data !== 1'b1 || state !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_prbs: data=%b state=%0d required data=1 state=2", data, state);
    end
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (data !== 1'b0 || state !== 2'd0 || underflow !== 1'b0 || busy !== 1'b0 ||
        word_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%b state=%0d uf=%b busy=%b rdy=%b done=%b required all 0",
               data, state, underflow, busy, word_ready, done);
    end
    tick();
    rstb = 1'b1;
    begin
      int ones = 0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (data !== 1'b0 || state !== 2'd0) ones++;
      end
      checks++;
      if (ones != 0) begin
        errors++;
        $display("FAIL idle_hold: nonzero/non-idle cycles=%0d required 0", ones);
      end
    end
  endtask

  task automatic test_full_sequence();
    logic [31:0]  pre_got, pre_exp;
    logic [126:0] prbs_got, prbs_exp;
    logic [15:0]  pay_got;
    logic [6:0]   ref_lfsr;
    do_reset();
    word = 16'hA5C3;
    word_valid = 1'b1;
    kick(16'd127);
    checks++;
    if (state !== 2'd1 || busy !== 1'b1 || data !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: state=%0d busy=%b data=%b required 1 1 0", state, busy, data);
    end
    prbs_len = 16'd5;  // must not matter, length was latched at start
    for (int i = 0; i < 32; i++) begin
      pre_exp[i] = (i % 2 == 0);
      tick();
      pre_got[i] = data;
    end
    checks++;
    if (pre_got !== pre_exp) begin
      errors++;
      $display("FAIL preamble: got=%h required=%h", pre_got, pre_exp);
    end
    ref_lfsr = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_exp[i] = ref_lfsr[6];
      ref_lfsr = {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
      tick();
      prbs_got[i] = data;
    end
    checks++;
    if (prbs_got[7:0] !== 8'b0111_1111) begin
      errors++;
      $display("FAIL prbs_head: got=%b required=01111111 (first bit rightmost)", prbs_got[7:0]);
    end
    checks++;
    if (prbs_got !== prbs_exp) begin
      errors++;
      $display("FAIL prbs_stream: got=%h required=%h", prbs_got, prbs_exp);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      pay_got[i] = data;
    end
    checks++;
    if (pay_got !== 16'hA5C3 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL payload_first: got=%h uf=%b required=a5c3 uf=0", pay_got, underflow);
    end
  endtask

  task automatic test_zero_prbs();
    logic [15:0] pay_got;
    do_reset();
    word = 16'h1234;
    word_valid = 1'b1;
    kick(16'd0);
    repeat (30) tick();
    checks++;
    if (word_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: ready=%b required 0 on preamble bit 31", word_ready);
    end
    tick();
    checks++;
    if (word_ready !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL ready_last_pre: ready=%b state=%0d required 1 1", word_ready, state);
    end
    tick();
    checks++;
    if (state !== 2'd3 || data !== 1'b0) begin
      errors++;
      $display("FAIL enter_data: state=%0d data=%b required 3 0", state, data);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      pay_got[i] = data;
    end
    checks++;
    if (pay_got !== 16'h1234) begin
      errors++;
      $display("FAIL payload_zero_prbs: got=%h required=1234", pay_got);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] tbl [5];
    logic [63:0] got, exp;
    logic [15:0] w5;
    int k;
    int zeros;
    tbl[0] = 16'h8001; tbl[1] = 16'h3C5A; tbl[2] = 16'hFFFF; tbl[3] = 16'h0F0E;
    tbl[4] = 16'h6B2D;
    exp = {tbl[3], tbl[2], tbl[1], tbl[0]};
    do_reset();
    k = 0;
    word = tbl[0];
    word_valid = 1'b1;
    kick(16'd0);
    for (int i = 0; i < 96; i++) begin
      if (word_ready && word_valid) k++;
      tick();
      if (i >= 32) got[i-32] = data;
      if (k < 4) word = tbl[k];
      else word_valid = 1'b0;
    end
    checks++;
    if (got !== exp || underflow !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: got=%h uf=%b required=%h uf=0", got, underflow, exp);
    end
    // Three empty slots, then word 5 is offered on the third one.
    zeros = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        word = tbl[4];
        word_valid = 1'b1;
      end
      tick();
      if (data !== 1'b0 || underflow !== 1'b1) zeros++;
    end
    word_valid = 1'b0;
    checks++;
    if (zeros != 0) begin
      errors++;
      $display("FAIL underflow_slots: bad slots=%0d required 0 (data 0, uf 1)", zeros);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      w5[i] = data;
    end
    checks++;
    if (w5 !== tbl[4] || underflow !== 1'b1) begin
      errors++;
      $display("FAIL after_underflow: got=%h uf=%b required=%h uf=1", w5, underflow, tbl[4]);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky_idle: state=%0d uf=%b required 0 1", state, underflow);
    end
    kick(16'd0);
    checks++;
    if (underflow !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL uf_clear_on_start: uf=%b state=%0d required 0 1", underflow, state);
    end
  endtask

  task automatic test_stop_prbs();
    do_reset();
    kick(16'd50);
    repeat (42) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 2'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_prbs: state=%0d done=%b busy=%b required 0 1 0", state, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL done_pulse_prbs: done=%b state=%0d required 0 0", done, state);
    end
  endtask

  task automatic test_stop_data();
    logic [10:0] got;
    int rdy_hi;
    do_reset();
    word = 16'hBEEF;
    word_valid = 1'b1;
    kick(16'd0);
    repeat (32) tick();
    repeat (5) tick();
    stop = 1'b1;
    rdy_hi = 0;
    for (int i = 0; i < 11; i++) begin
      if (word_ready !== 1'b0 && i > 0) rdy_hi++;
      tick();
      stop = 1'b0;
      got[i] = data;
      if (i < 10 && done !== 1'b0) rdy_hi++;
    end
    checks++;
    if (got !== 11'h5F7) begin
      errors++;
      $display("FAIL stop_data_tail: got=%h required=5f7", got);
    end
    checks++;
    if (rdy_hi != 0) begin
      errors++;
      $display("FAIL stop_data_ready: bad ready/done cycles=%0d required 0", rdy_hi);
    end
    checks++;
    if (state !== 2'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL stop_data_idle: state=%0d done=%b required 0 1", state, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_data: done=%b required 0", done);
    end
    word_valid = 1'b0;
  endtask

  task automatic test_corners();
    do_reset();
    start = 1'b1;
    stop = 1'b1;
    prbs_len = 16'd4;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_and_stop: state=%0d busy=%b required 0 0", state, busy);
    end
    kick(16'd3);
    prbs_len = 16'd100;
    repeat (34) tick();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL latched_len_mid: state=%0d required 2", state);
    end
    tick();
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL latched_len_end: state=%0d required 3", state);
    end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if (state !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_data: state=%0d busy=%b required 3 1", state, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 2'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL stop_empty_data: state=%0d done=%b required 0 1", state, done);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_zero_prbs();
    test_back_to_back();
    test_stop_prbs();
    test_stop_data();
    test_corners();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
